// File: rtl/vga_sync_gen_if.sv
// ----------------------------------------------------------------------------
// vga_sync_gen_if
// Bundle of raster-timing outputs produced by vga_sync_gen.
//   pix_x, pix_y  : current pixel / line count (10 bits each)
//   hsync, vsync  : active-low sync pulses for the VGA connector
//   video_on      : high inside the visible area
//   p_tick        : one-clock pulse marking a pixel advance
//   frame_tick    : one-clock pulse on the last pixel of a frame
// master modport : the timing generator (drives everything)
// slave modport  : pixel generators / RGB mux (read only)
// ----------------------------------------------------------------------------
interface vga_sync_gen_if;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic       frame_tick;

    modport master (
        output pix_x, pix_y, hsync, vsync, video_on, p_tick, frame_tick
    );

    modport slave (
        input  pix_x, pix_y, hsync, vsync, video_on, p_tick, frame_tick
    );
endinterface

// File: rtl/vga_sync_gen.sv
// ----------------------------------------------------------------------------
// vga_sync_gen
// VGA raster timing generator: a clock divider produces the pixel tick, which
// advances horizontal and vertical counters; sync pulses are registered from
// the next-state counter values so they switch on the same edge as the
// counters. Default timing is 640x480 @ 60 Hz from a 100 MHz clock.
// Ports:
//   clk_i   : system clock, rising edge
//   rst_n_i : asynchronous active-low reset (restarts the frame at 0,0)
//   vga     : vga_sync_gen_if.master (pix_x, pix_y, hsync, vsync, video_on,
//             p_tick, frame_tick)
// ----------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int PIX_DIV   = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    vga_sync_gen_if.master   vga
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    // Counters are 10 bits wide, so the raster must fit in 1024x1024.
    if (H_TOTAL > 1024) begin : g_bad_h_total
        $error("vga_sync_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_bad_v_total
        $error("vga_sync_gen: V_TOTAL exceeds 1024");
    end
    if (PIX_DIV < 1) begin : g_bad_pix_div
        $error("vga_sync_gen: PIX_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             p_tick_s;

    // With PIX_DIV=1 the divider sits at 0 == DIV_LAST, so p_tick is held high.
    assign p_tick_s = (div_q == DIV_LAST);

    // Next-state for divider, raster counters and the syncs derived from them.
    always_comb begin
        div_d   = div_q;
        x_d     = x_q;
        y_d     = y_q;
        hsync_d = 1'b1;
        vsync_d = 1'b1;

        if (p_tick_s) begin
            div_d = '0;
            if (x_q == H_LAST) begin
                x_d = 10'd0;
                if (y_q == V_LAST) begin
                    y_d = 10'd0;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
                y_d = y_q;
            end
        end else begin
            div_d = div_q + DIV_ONE;
            x_d   = x_q;
            y_d   = y_q;
        end

        // Decoding the next-state counters keeps syncs aligned to pix_x/pix_y.
        if ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) begin
            hsync_d = 1'b0;
        end else begin
            hsync_d = 1'b1;
        end

        if ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) begin
            vsync_d = 1'b0;
        end else begin
            vsync_d = 1'b1;
        end
    end

    // State registers; reset restarts the raster at (0,0) with syncs idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q   <= '0;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign vga.pix_x      = x_q;
    assign vga.pix_y      = y_q;
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.p_tick     = p_tick_s;
    assign vga.video_on   = (x_q < H_VIS) && (y_q < V_VIS);
    assign vga.frame_tick = p_tick_s && (x_q == H_LAST) && (y_q == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_gen
// Three generators share clock and reset: default 640x480 timing (PIX_DIV=4),
// and a small 15x10 raster at PIX_DIV=3 and PIX_DIV=1 so whole frames fit in
// a short run. Expected outputs are computed arithmetically from the number of
// clock edges since reset release.
// ----------------------------------------------------------------------------
module tb_vga_sync_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;   // clock edges seen since the last reset release

    always #5 clk = ~clk;

    vga_sync_gen_if vif0 ();
    vga_sync_gen_if vif1 ();
    vga_sync_gen_if vif2 ();

    vga_sync_gen dut0 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .vga     (vif0)
    );

    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .PIX_DIV(3)
    ) dut1 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .vga     (vif1)
    );

    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .PIX_DIV(1)
    ) dut2 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .vga     (vif2)
    );

    // Reference: after c clock edges, floor(c/div) pixels have elapsed.
    function automatic logic [31:0] model(input int c,
                                          input int hd, input int hf,
                                          input int hs, input int hb,
                                          input int vd, input int vf,
                                          input int vs, input int vb,
                                          input int dv);
        int ht, vt, n, x, y;
        logic pt, ft, hsy, vsy, vo;
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        n   = c / dv;
        x   = n % ht;
        y   = (n / ht) % vt;
        pt  = ((c % dv) == dv - 1);
        ft  = pt && (x == ht - 1) && (y == vt - 1);
        hsy = !((x >= hd + hf) && (x < hd + hf + hs));
        vsy = !((y >= vd + vf) && (y < vd + vf + vs));
        vo  = (x < hd) && (y < vd);
        model = {7'd0, 10'(x), 10'(y), hsy, vsy, vo, pt, ft};
    endfunction

    function automatic logic [31:0] exp0(input int c);
        exp0 = model(c, 640, 16, 96, 48, 480, 10, 2, 33, 4);
    endfunction
    function automatic logic [31:0] exp1(input int c);
        exp1 = model(c, 8, 2, 3, 2, 6, 1, 2, 1, 3);
    endfunction
    function automatic logic [31:0] exp2(input int c);
        exp2 = model(c, 8, 2, 3, 2, 6, 1, 2, 1, 1);
    endfunction

    function automatic logic [31:0] obs0();
        obs0 = {7'd0, vif0.pix_x, vif0.pix_y, vif0.hsync, vif0.vsync,
                vif0.video_on, vif0.p_tick, vif0.frame_tick};
    endfunction
    function automatic logic [31:0] obs1();
        obs1 = {7'd0, vif1.pix_x, vif1.pix_y, vif1.hsync, vif1.vsync,
                vif1.video_on, vif1.p_tick, vif1.frame_tick};
    endfunction
    function automatic logic [31:0] obs2();
        obs2 = {7'd0, vif2.pix_x, vif2.pix_y, vif2.hsync, vif2.vsync,
                vif2.video_on, vif2.p_tick, vif2.frame_tick};
    endfunction

    // Values are {x[9:0], y[9:0], hsync, vsync, video_on, p_tick, frame_tick}.
    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s t=%0t cyc=%0d got=%h expected=%h",
                     tag, $time, cyc, obs, exp);
        end
    endtask

    // Edge count since release; async clear mirrors the DUT reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Every output of every instance is compared away from the active edge.
    always @(negedge clk) begin
        check_val("run0", obs0(), exp0(cyc));
        check_val("run1", obs1(), exp1(cyc));
        check_val("run2", obs2(), exp2(cyc));
    end

    task automatic check_reset_now(input string tag);
        check_val({tag, "0"}, obs0(), exp0(0));
        check_val({tag, "1"}, obs1(), exp1(0));
        check_val({tag, "2"}, obs2(), exp2(0));
    endtask

    // Assert reset asynchronously between edges and check outputs at once.
    task automatic pulse_reset(input string tag, input int hold);
        rst_n = 1'b0;
        #1;
        check_reset_now(tag);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int waited;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_now("rst_init");
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Free run: more than two full default lines, many small frames.
        repeat (7000) @(posedge clk);

        // Randomly placed reset pulses, including mid-line.
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(1, 900)) @(posedge clk);
            #($urandom_range(1, 8));
            pulse_reset("rst_rand", int'($urandom_range(0, 3)));
        end

        // Reset landing in the clock where frame_tick is high must win.
        repeat (20) @(posedge clk);
        waited = 0;
        @(negedge clk);
        while (vif1.frame_tick !== 1'b1 && waited < 1000) begin
            @(negedge clk);
            waited = waited + 1;
        end
        check_val("ft_seen", {31'd0, vif1.frame_tick}, 32'd1);
        #1;
        pulse_reset("rst_ft", 2);

        // Resume and let everything run through frame wraps again.
        repeat (4000) @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
